// File: rtl/opcode_pkg.sv
// Shared opcode and fetch-state definitions for the 8-bit core.
package opcode_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned INSTR_W  = 8;

    typedef enum logic [OPCODE_W-1:0] {
        OPCODE_NOP = 4'h0,
        OPCODE_LD  = 4'h1,
        OPCODE_ST  = 4'h2,
        OPCODE_ADD = 4'h3,
        OPCODE_SUB = 4'h4,
        OPCODE_AND = 4'h5,
        OPCODE_OR  = 4'h6,
        OPCODE_XOR = 4'h7,
        OPCODE_BR  = 4'hC
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        OPERAND = 3'd2,
        RESOLVE = 3'd3,
        EXEC    = 3'd4
    } fetch_state_t;

    // True when the instruction byte carries the branch opcode in its top nibble.
    function automatic logic is_branch(input logic [INSTR_W-1:0] ir);
        return ir[INSTR_W-1 -: OPCODE_W] == OPCODE_W'(OPCODE_BR);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter and instruction-fetch controller.
// Optional: FETCH_SEQ_BRANCH_CNT_EN adds a saturating taken-branch counter output.
module fetch_sequencer
    import opcode_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]   RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr,
    input  logic              do_branch,
    output logic              instr_valid,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc
`ifdef FETCH_SEQ_BRANCH_CNT_EN
    ,
    output logic [7:0]        br_taken_cnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        instr_q, instr_d;
    logic [7:0]        tgt_q, tgt_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_inc1, pc_inc2;
    logic              rd_done;

`ifdef FETCH_SEQ_BRANCH_CNT_EN
    logic [7:0]        br_cnt_q, br_cnt_d;
`endif

    // A read completes only when our own request is outstanding.
    assign rd_done = req_q && mem_ack;
    assign pc_inc1 = pc_q + ADDR_W'(1);
    assign pc_inc2 = pc_q + ADDR_W'(2);

    // State and registered outputs; reset abandons any outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_VEC;
            addr_q  <= RESET_VEC;
            instr_q <= 8'h00;
            tgt_q   <= 8'h00;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    // Next-state, PC update and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        tgt_d   = tgt_q;
        valid_d = 1'b0;

        case (state_q)
            FETCH: begin
                if (rd_done) begin
                    instr_d = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_branch(instr_q)) begin
                    state_d = OPERAND;
                end else begin
                    valid_d = 1'b1;
                    state_d = EXEC;
                end
            end
            OPERAND: begin
                if (rd_done) begin
                    tgt_d   = mem_rdata;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                pc_d    = do_branch ? ADDR_W'(tgt_q) : pc_inc2;
                state_d = FETCH;
            end
            EXEC: begin
                if (exec_done) begin
                    pc_d    = pc_inc1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Request and address follow the state being entered, so both are
        // fixed for the whole time the request is high.
        req_d  = (state_d == FETCH) || (state_d == OPERAND);
        addr_d = (state_d == OPERAND) ? pc_inc1 : pc_d;
    end

`ifdef FETCH_SEQ_BRANCH_CNT_EN
    // Saturating count of branches resolved as taken.
    always_comb begin
        br_cnt_d = br_cnt_q;
        if (state_q == RESOLVE && do_branch && br_cnt_q != 8'hFF) begin
            br_cnt_d = br_cnt_q + 8'd1;
        end
    end

    // Taken-branch counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= 8'h00;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end

    assign br_taken_cnt = br_cnt_q;
`endif

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (optionally FETCH_SEQ_BRANCH_CNT_EN).
module tb_fetch_sequencer;
    import opcode_pkg::*;

    logic       clk;
    logic       rst;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] instr;
    logic       do_branch;
    logic       instr_valid;
    logic       exec_done;
    logic [7:0] pc;
`ifdef FETCH_SEQ_BRANCH_CNT_EN
    logic [7:0] br_taken_cnt;
`endif

    logic [7:0] mem [256];
    int         n_checks;
    int         n_errors;
    int         valid_cnt;
    logic [7:0] br_op;

    fetch_sequencer #(.ADDR_W(8), .RESET_VEC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .do_branch   (do_branch),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .pc          (pc)
`ifdef FETCH_SEQ_BRANCH_CNT_EN
        ,
        .br_taken_cnt(br_taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count instr_valid pulses seen at each rising edge.
    always @(posedge clk) begin
        if (instr_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Answer one read after 'waits' idle cycles, checking the address is held.
    task automatic serve(input logic [7:0] exp_addr, input int waits, input string tag);
        bit ok;
        bit stable;
        wait_req(ok);
        check({tag, "_req"}, 32'(ok), 32'd1);
        if (!ok) return;
        check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        stable = 1'b1;
        for (int i = 0; i < waits; i++) begin
            step();
            if (!(mem_req === 1'b1 && mem_addr === exp_addr)) stable = 1'b0;
        end
        if (waits > 0) check({tag, "_hold"}, 32'(stable), 32'd1);
        mem_rdata = mem[mem_addr];
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
    endtask

    task automatic run_nonbranch(input logic [7:0] a, input int waits, input logic [7:0] exp_ir,
                                 input logic [7:0] next_a, input string tag);
        int v0;
        serve(a, waits, {tag, "_op"});
        v0 = valid_cnt;
        check({tag, "_ir"}, 32'(instr), 32'(exp_ir));
        check({tag, "_req_low"}, 32'(mem_req), 32'd0);
        exec_done = 1'b0;
        for (int i = 0; i < 3; i++) step();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check({tag, "_pulses"}, 32'(valid_cnt - v0), 32'd1);
        check({tag, "_next_req"}, 32'(mem_req), 32'd1);
        check({tag, "_next_addr"}, 32'(mem_addr), 32'(next_a));
    endtask

    task automatic run_branch(input logic [7:0] a, input logic [7:0] op_a, input bit taken,
                              input logic [7:0] next_a, input string tag);
        int v0;
        v0 = valid_cnt;
        do_branch = taken;
        serve(a, 0, {tag, "_op"});
        check({tag, "_ir"}, 32'(instr), 32'(br_op));
        serve(op_a, 1, {tag, "_tgt"});
        step();
        do_branch = 1'b0;
        check({tag, "_next_req"}, 32'(mem_req), 32'd1);
        check({tag, "_next_addr"}, 32'(mem_addr), 32'(next_a));
        check({tag, "_pc"}, 32'(pc), 32'(next_a));
        check({tag, "_no_valid"}, 32'(valid_cnt - v0), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        valid_cnt = 0;
        br_op     = {4'(OPCODE_BR), 4'h0};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h12;
        mem[8'h01] = br_op; mem[8'h02] = 8'h05;
        mem[8'h05] = br_op; mem[8'h06] = 8'h40;
        mem[8'h07] = br_op; mem[8'h08] = 8'hFF;
        mem[8'h40] = br_op; mem[8'h41] = 8'h05;
        mem[8'hFF] = br_op;
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00; do_branch = 1'b0; exec_done = 1'b0;

        // Reset
        step(); step();
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_ir", 32'(instr), 32'h00);
        rst = 1'b0;
        step();
        check("rel_req", 32'(mem_req), 32'd1);
        check("rel_addr", 32'(mem_addr), 32'h00);

        // Non-branch with wait states
        run_nonbranch(8'h00, 3, 8'h12, 8'h01, "nb");
        // 01 -> 05 taken, then taken at 05 -> 40
        run_branch(8'h01, 8'h02, 1'b1, 8'h05, "br01");
        run_branch(8'h05, 8'h06, 1'b1, 8'h40, "taken");
        // Back to 05 and not taken -> 07
        run_branch(8'h40, 8'h41, 1'b1, 8'h05, "br40");
        run_branch(8'h05, 8'h06, 1'b0, 8'h07, "ntaken");
        // Reach FF, then wrap on a not-taken branch
        run_branch(8'h07, 8'h08, 1'b1, 8'hFF, "brff");
        run_branch(8'hFF, 8'h00, 1'b0, 8'h01, "wrap");

        // Reset during the operand read, then a stray ack
        serve(8'h01, 0, "mid_op");
        begin
            bit ok;
            wait_req(ok);
            check("mid_opnd_req", 32'(ok), 32'd1);
            check("mid_opnd_addr", 32'(mem_addr), 32'h02);
        end
        rst = 1'b1;
        step(); step();
        check("mid_rst_pc", 32'(pc), 32'h00);
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_ir", 32'(instr), 32'h00);
`ifdef FETCH_SEQ_BRANCH_CNT_EN
        check("cnt_rst", 32'(br_taken_cnt), 32'h00);
`endif
        rst = 1'b0;
        mem_rdata = 8'h99;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("stray_req", 32'(mem_req), 32'd1);
        check("stray_addr", 32'(mem_addr), 32'h00);
        check("stray_ir", 32'(instr), 32'h00);
        run_nonbranch(8'h00, 0, 8'h12, 8'h01, "restart");

`ifdef FETCH_SEQ_BRANCH_CNT_EN
        // Saturation: one taken at 01, then loop at 05 with target 05
        mem[8'h06] = 8'h05;
        run_branch(8'h01, 8'h02, 1'b1, 8'h05, "cnt_first");
        for (int i = 0; i < 253; i++) run_branch(8'h05, 8'h06, 1'b1, 8'h05, "cnt_loop");
        check("cnt_fe", 32'(br_taken_cnt), 32'hFE);
        for (int i = 0; i < 46; i++) run_branch(8'h05, 8'h06, 1'b1, 8'h05, "cnt_sat");
        check("cnt_ff", 32'(br_taken_cnt), 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
